// File: rtl/dot_product_accumulator.sv
// dot_product_accumulator: streams VECTOR_LEN unsigned element pairs per vector
// through a multiply stage and an accumulate stage, presenting one dot product
// per vector with a valid/ready handshake, NUMBER_OF_VECTORS vectors per run.
// Build option: define DOT_PRODUCT_SATURATE_EN to clamp the accumulator at
// 2^ACC_WIDTH-1 on overflow; otherwise it wraps modulo 2^ACC_WIDTH.
module dot_product_accumulator #(
  parameter int DATA_WIDTH        = 8,
  parameter int VECTOR_LEN        = 8,
  parameter int NUMBER_OF_VECTORS = 4,
  parameter int ACC_WIDTH         = 2*DATA_WIDTH + $clog2(VECTOR_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  in_ready,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [((NUMBER_OF_VECTORS > 1) ? $clog2(NUMBER_OF_VECTORS) : 1)-1:0] vec_idx,
  output logic                  overflow,
  output logic                  busy,
  output logic                  done
);

  localparam int PW = 2*DATA_WIDTH;
  localparam int SW = ((ACC_WIDTH > PW) ? ACC_WIDTH : PW) + 1;
  localparam int EW = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
  localparam int VW = (NUMBER_OF_VECTORS > 1) ? $clog2(NUMBER_OF_VECTORS) : 1;
  localparam logic [EW-1:0] LAST_ELEM = EW'(VECTOR_LEN - 1);
  localparam logic [VW-1:0] LAST_VEC  = VW'(NUMBER_OF_VECTORS - 1);

  typedef enum logic [2:0] {IDLE, ACCUM, FLUSH, HOLD, DONE} state_t;

  state_t          state;
  logic [EW-1:0]   elem_cnt;
  logic            flush_second;
  logic [PW-1:0]   prod;
  logic            prod_vld;
  logic [ACC_WIDTH-1:0] acc;
  logic [SW-1:0]   sum;
  logic            carry;
  logic            accept;
  logic            acc_clr;

  assign accept  = in_valid && in_ready;
  // Accumulator restarts on a new run and whenever a held result is taken.
  assign acc_clr = ((state == IDLE) && start) || ((state == HOLD) && result_ready);

  // Widened add so the carry out of ACC_WIDTH is visible.
  always_comb begin
    sum   = SW'(acc) + SW'(prod);
    carry = (sum >> ACC_WIDTH) != '0;
  end

  // Control FSM with all handshake/status outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      elem_cnt     <= '0;
      flush_second <= 1'b0;
      in_ready     <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      vec_idx      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACCUM;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            elem_cnt <= '0;
            vec_idx  <= '0;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (elem_cnt == LAST_ELEM) begin
              state        <= FLUSH;
              in_ready     <= 1'b0;
              flush_second <= 1'b0;
            end else begin
              elem_cnt <= elem_cnt + EW'(1);
            end
          end
        end
        FLUSH: begin
          // Two cycles: one for the product register, one for the final add.
          if (flush_second) begin
            state        <= HOLD;
            result       <= acc;
            result_valid <= 1'b1;
          end else begin
            flush_second <= 1'b1;
          end
        end
        HOLD: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            if (vec_idx == LAST_VEC) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= ACCUM;
              in_ready <= 1'b1;
              elem_cnt <= '0;
              vec_idx  <= vec_idx + VW'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-stage datapath: register the product, then fold it into the accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
      overflow <= 1'b0;
    end else begin
      prod_vld <= accept;
      if (accept) begin
        prod <= PW'(in_a) * PW'(in_b);
      end
      if (acc_clr) begin
        acc      <= '0;
        overflow <= 1'b0;
      end else if (prod_vld) begin
        overflow <= overflow | carry;
`ifdef DOT_PRODUCT_SATURATE_EN
        acc <= carry ? '1 : sum[ACC_WIDTH-1:0];
`else
        acc <= sum[ACC_WIDTH-1:0];
`endif
      end
    end
  end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Randomized self-checking bench for dot_product_accumulator (default build and
// a narrow ACC_WIDTH=16 instance for overflow behaviour).
module tb_dot_product_accumulator;

  localparam int DW = 8;
  localparam int VL = 8;
  localparam int NV = 4;
  localparam int AW = 2*DW + $clog2(VL);
`ifdef DOT_PRODUCT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, in_valid, result_ready;
  logic [DW-1:0] in_a, in_b;
  logic          in_ready, result_valid, overflow, busy, done;
  logic [AW-1:0] result;
  logic [1:0]    vec_idx;

  logic          start2, in_valid2, result_ready2;
  logic [DW-1:0] in_a2, in_b2;
  logic          in_ready2, result_valid2, overflow2, busy2, done2;
  logic [15:0]   result2;
  logic [0:0]    vec_idx2;

  dot_product_accumulator #(
    .DATA_WIDTH(DW), .VECTOR_LEN(VL), .NUMBER_OF_VECTORS(NV), .ACC_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_ready(in_ready), .result(result),
    .result_valid(result_valid), .result_ready(result_ready),
    .vec_idx(vec_idx), .overflow(overflow), .busy(busy), .done(done)
  );

  dot_product_accumulator #(
    .DATA_WIDTH(8), .VECTOR_LEN(2), .NUMBER_OF_VECTORS(2), .ACC_WIDTH(16)
  ) dut_narrow (
    .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2),
    .in_a(in_a2), .in_b(in_b2), .in_ready(in_ready2), .result(result2),
    .result_valid(result_valid2), .result_ready(result_ready2),
    .vec_idx(vec_idx2), .overflow(overflow2), .busy(busy2), .done(done2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: exact sum of products, then reduced to the accumulator width.
  function automatic longint model(input longint total, input int w, output bit ovf);
    longint lim;
    lim = longint'(1) << w;
    ovf = (total >= lim);
    if (SAT) return ovf ? lim - 1 : total;
    return total % lim;
  endfunction

  // pat: 0 random, 1 a=1..VL b=1, 2 all 255. vmode: 0 continuous, 1 toggle, 2 random.
  task automatic run(input int pat, input int vmode, input int stall, input bit poke,
                     input int abort_vec, input int abort_elem);
    longint total, exp;
    bit     eovf, seen;
    int     cnt, guard, k;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int v = 0; v < NV; v++) begin
      total = 0; cnt = 0; guard = 0;
      result_ready = (stall == 0);
      while (cnt < VL) begin
        in_a     = (pat == 1) ? DW'(cnt + 1) : (pat == 2) ? 8'hff : DW'($urandom);
        in_b     = (pat == 1) ? 8'd1 : (pat == 2) ? 8'hff : DW'($urandom);
        in_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? (guard % 2 == 0) : 1'($urandom);
        start    = poke ? 1'($urandom) : 1'b0;
        if (in_valid && in_ready) begin
          total += longint'(in_a) * longint'(in_b);
          cnt++;
        end
        guard++;
        @(negedge clk);
        if (v == abort_vec && cnt == abort_elem) begin
          rst = 1'b1; in_valid = 1'b0; start = 1'b0;
          #1;
          check("rst_result", result, 0);
          check("rst_flags", {result_valid, overflow, in_ready, busy, done}, 0);
          check("rst_vec_idx", vec_idx, 0);
          @(negedge clk); rst = 1'b0;
          seen = 1'b0;
          for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (result_valid || done || busy) seen = 1'b1;
          end
          check("post_rst_quiet", seen, 0);
          return;
        end
        if (guard > 200) begin
          check("accept_timeout", cnt, VL);
          return;
        end
      end
      // Pairs offered during the flush must not be consumed.
      start = 1'b0; in_valid = 1'b1; in_a = DW'($urandom); in_b = DW'($urandom);
      k = 1;
      while (!result_valid && k < 10) begin
        check("flush_in_ready", in_ready, 0);
        @(negedge clk); k++;
      end
      check("latency", k, 3);
      in_valid = 1'b0;
      exp = model(total, AW, eovf);
      for (int i = 0; i < stall; i++) begin
        check("hold_result", result, exp);
        check("hold_valid", result_valid, 1);
        check("hold_in_ready", in_ready, 0);
        @(negedge clk);
      end
      check("result", result, exp);
      check("vec_idx", vec_idx, v);
      check("overflow", overflow, eovf);
      result_ready = 1'b1;
      @(negedge clk);
      check("valid_drop", result_valid, 0);
      if (v < NV - 1) begin
        check("next_in_ready", in_ready, 1);
      end else begin
        check("done_pulse", done, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_clear", done, 0);
        check("busy_clear", busy, 0);
      end
    end
  endtask

  task automatic run_narrow();
    longint exp;
    bit     eovf;
    int     k;
    exp = model(2 * 65025, 16, eovf);
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    for (int v = 0; v < 2; v++) begin
      in_valid2 = 1'b1; in_a2 = 8'hff; in_b2 = 8'hff;
      check("narrow_in_ready", in_ready2, 1);
      @(negedge clk);
      @(negedge clk);
      in_valid2 = 1'b0;
      k = 0;
      while (!result_valid2 && k < 10) begin
        @(negedge clk); k++;
      end
      check("narrow_result", result2, exp);
      check("narrow_overflow", overflow2, eovf);
      check("narrow_vec_idx", vec_idx2, v);
      result_ready2 = 1'b1;
      @(negedge clk);
      result_ready2 = 1'b0;
      check("narrow_ovf_clear", overflow2, 0);
    end
    check("narrow_done", done2, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; result_ready = 1'b0;
    start2 = 1'b0; in_valid2 = 1'b0; in_a2 = '0; in_b2 = '0; result_ready2 = 1'b0;
    #12;
    check("reset_result", result, 0);
    check("reset_flags", {result_valid, overflow, in_ready, busy, done}, 0);
    check("reset_vec_idx", vec_idx, 0);
    @(negedge clk); rst = 1'b0;
    run(1, 0, 0, 1'b0, -1, -1);
    run(2, 0, 0, 1'b0, -1, -1);
    run(0, 2, 10, 1'b0, -1, -1);
    run(1, 1, 0, 1'b1, -1, -1);
    run(1, 0, 0, 1'b0, 1, 5);
    run(1, 0, 0, 1'b0, -1, -1);
    for (int r = 0; r < 3; r++) run(0, 2, int'($urandom_range(0, 4)), 1'b1, -1, -1);
    run_narrow();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
